// File: rtl/data_memory_bytelane_pkg.sv
// Shared definitions for the byte-lane data memory: access size codes,
// clear/ready FSM encoding and the control word carried down the response
// pipeline next to the raw array word.
package data_memory_bytelane_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_t;

  // Everything the response path needs to turn a raw word into load data.
  typedef struct packed {
    logic       wen;
    logic       mis;
    logic [1:0] size;
    logic [1:0] lane;
    logic       uns;
  } resp_ctl_t;

endpackage

// File: rtl/data_memory_bytelane_lane_align.sv
// dmem_lane_align: purely combinational lane steering.
//   store side: st_size, st_lane, st_wdata -> st_be (byte enables),
//               st_data (wdata replicated across lanes), st_misalign
//   load side : ld_word, ld_size, ld_lane, ld_unsigned -> ld_data
//               (selected byte/half, sign- or zero-extended)
module dmem_lane_align
  import data_memory_bytelane_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  output logic        st_misalign,
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
    logic        mis;
  } st_align_t;

  function automatic st_align_t store_align(input logic [1:0] size, input logic [1:0] lane,
                                            input logic [31:0] wdata);
    st_align_t r;
    r.be   = 4'b0000;
    r.data = wdata;
    r.mis  = 1'b0;
    case (size)
      SIZE_B: begin
        r.data = {4{wdata[7:0]}};
        r.be   = 4'b0001 << lane;
      end
      SIZE_H: begin
        r.data = {2{wdata[15:0]}};
        r.mis  = lane[0];
        r.be   = 4'b0011 << lane;
      end
      SIZE_W: begin
        r.mis  = (lane != 2'b00);
        r.be   = 4'b1111;
      end
      default: r.mis = 1'b1;
    endcase
    // A misaligned store must not touch the array at all.
    if (r.mis) r.be = 4'b0000;
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    // Bring the addressed lane down to bit 0; for halfwords lane is 0 or 2.
    sh = word >> {lane, 3'b000};
    case (size)
      SIZE_B:  r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SIZE_W:  r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  st_align_t st;

  always_comb begin
    st          = store_align(st_size, st_lane, st_wdata);
    st_be       = st.be;
    st_data     = st.data;
    st_misalign = st.mis;
    ld_data     = load_extend(ld_word, ld_size, ld_lane, ld_unsigned);
  end

endmodule

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: 32-bit-word data memory with byte/half/word access.
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake (ready low while clearing)
//   req_wen, req_size,          store/load, access size, zero-extend select,
//   req_unsigned, req_addr,     byte address, right-justified store data
//   req_wdata
//   resp_valid, resp_rdata,     one response per accepted request,
//   resp_misalign               READ_LATENCY cycles after acceptance
//
// state    | meaning
// DM_CLEAR | zero-fill sweep, one word per cycle, requests refused
// DM_READY | normal operation, requests accepted
module data_memory_bytelane
  import data_memory_bytelane_pkg::*;
#(
  parameter int    ADDR_WIDTH   = 10,
  parameter int    READ_LATENCY = 1,
  parameter int    INIT_MODE    = 0,
  parameter string INIT_FILE    = "data.txt"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misalign
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           dm [DEPTH];
  dm_state_t             state;
  logic [ADDR_WIDTH-1:0] clr_ptr;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] widx;
  logic [1:0]            lane;
  logic [3:0]            st_be;
  logic [31:0]           st_data;
  logic                  st_mis;

  logic                  s1_valid;
  resp_ctl_t             s1_ctl;
  logic [31:0]           s1_word;

  logic                  out_valid;
  resp_ctl_t             out_ctl;
  logic [31:0]           out_word;
  logic [31:0]           ld_data;

  assign accept = req_valid && req_ready;
  assign widx   = req_addr[ADDR_WIDTH+1:2];
  assign lane   = req_addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= (INIT_MODE == 1) ? DM_CLEAR : DM_READY;
      req_ready <= (INIT_MODE != 1);
      clr_ptr   <= '0;
    end else begin
      case (state)
        DM_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == '1) begin
            state     <= DM_READY;
            req_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array and raw read data carry no reset; the sweep and the gated
  // response outputs make that invisible.
  always_ff @(posedge clk) begin
    if (state == DM_CLEAR) begin
      dm[clr_ptr] <= '0;
    end else if (accept && req_wen) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) dm[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
    if (accept) s1_word <= dm[widx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctl   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ctl <= '{wen: req_wen, mis: st_mis, size: req_size, lane: lane, uns: req_unsigned};
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_rl2
    logic        s2_valid;
    resp_ctl_t   s2_ctl;
    logic [31:0] s2_word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_ctl   <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_ctl   <= s1_ctl;
      end
    end

    always_ff @(posedge clk) s2_word <= s1_word;

    assign out_valid = s2_valid;
    assign out_ctl   = s2_ctl;
    assign out_word  = s2_word;
  end else begin : g_rl1
    assign out_valid = s1_valid;
    assign out_ctl   = s1_ctl;
    assign out_word  = s1_word;
  end

  dmem_lane_align u_align (
    .st_size     (req_size),
    .st_lane     (lane),
    .st_wdata    (req_wdata),
    .st_be       (st_be),
    .st_data     (st_data),
    .st_misalign (st_mis),
    .ld_word     (out_word),
    .ld_size     (out_ctl.size),
    .ld_lane     (out_ctl.lane),
    .ld_unsigned (out_ctl.uns),
    .ld_data     (ld_data)
  );

  // Outputs are forced to zero outside a valid beat so that an async reset
  // drops them at once; stores and misaligned accesses return zero data.
  assign resp_valid    = out_valid;
  assign resp_misalign = out_valid & out_ctl.mis;
  assign resp_rdata    = (out_valid && !out_ctl.wen && !out_ctl.mis) ? ld_data : 32'h0;

endmodule
